// File: rtl/event_readout.sv
// event_readout: timestamps committed trigger events into a FIFO and serves
// them to the MCU through an oversampled mode-0 SPI slave.
`default_nettype none

module event_readout #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 24
) (
  input  logic              pll_clk,
  input  logic              reset,
  input  logic              commit_valid,
  input  logic [23:0]       commit_data,
  input  logic              spi_clk,
  input  logic              spi_cs,
  output logic              spi_so,
  output logic              irq_n,
  output logic              overflow,
  output logic [5:0]        fifo_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int REC_W = TS_W + 24;
  localparam int SR_W  = REC_W + 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  logic [TS_W-1:0]  r_ts;
  logic [REC_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             r_overflow;
  logic [2:0]       r_sck_sync;
  logic [2:0]       r_cs_sync;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [SR_W-1:0]  r_shreg;
  logic [5:0]       r_bit_cnt;
  logic             r_snap_empty;
  logic             r_so;

  logic [PW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_sck_fall;
  logic             w_cs_fall;
  logic             w_cs_rise;
  logic             w_cs_high;
  logic             w_load;
  logic             w_shift;
  logic             w_frame_end;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [7:0]       w_header;
  logic [REC_W-1:0] w_head_rec;

  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_count == PW'(DEPTH));
  assign w_empty    = (w_count == '0);
  assign fifo_count = 6'(w_count);
  assign irq_n      = w_empty;
  assign overflow   = r_overflow;
  assign spi_so     = r_so;

  assign w_sck_fall = r_sck_sync[2] & ~r_sck_sync[1];
  assign w_cs_fall  = r_cs_sync[2] & ~r_cs_sync[1];
  assign w_cs_rise  = ~r_cs_sync[2] & r_cs_sync[1];
  assign w_cs_high  = r_cs_sync[1];

  assign w_header   = {w_empty, r_overflow, fifo_count};
  assign w_head_rec = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  assign w_pop  = w_frame_end & ~r_snap_empty;
  assign w_push = commit_valid & (~w_full | w_pop);
  assign w_drop = commit_valid & ~w_push;

  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end

  // Synchronizers clear low so a CS already low at reset release is not seen as a fall.
  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      r_sck_sync <= '0;
      r_cs_sync  <= '0;
    end else begin
      r_sck_sync <= {r_sck_sync[1:0], spi_clk};
      r_cs_sync  <= {r_cs_sync[1:0], spi_cs};
    end
  end

  always_ff @(posedge pll_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {r_ts, commit_data};
    end
  end

  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_frame_end) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sck_fall) begin
          w_shift = 1'b1;
          if (r_bit_cnt == 6'd55) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_cs_rise) begin
          w_frame_end = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The header MSB goes straight to r_so, so the shift register holds only the remaining 55 bits.
  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_snap_empty <= 1'b1;
      r_so         <= 1'b0;
    end else begin
      if (w_load) begin
        r_shreg      <= {w_header[6:0], w_head_rec};
        r_bit_cnt    <= '0;
        r_snap_empty <= w_empty;
      end else if (w_shift) begin
        r_shreg   <= r_shreg << 1;
        r_bit_cnt <= r_bit_cnt + 6'd1;
      end

      if (w_cs_high) begin
        r_so <= 1'b0;
      end else if (w_load) begin
        r_so <= w_header[7];
      end else if (w_shift) begin
        r_so <= (r_bit_cnt == 6'd55) ? 1'b0 : r_shreg[SR_W-1];
      end else if (r_state != ST_SHIFT) begin
        r_so <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_event_readout.sv
// tb_event_readout: directed stimulus with a scoreboard-driven SPI frame monitor.
`default_nettype none
`timescale 1ns/1ps

module tb_event_readout;

  logic        pll_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        commit_valid = 1'b0;
  logic [23:0] commit_data = '0;
  logic        spi_clk = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_so;
  logic        irq_n;
  logic        overflow;
  logic [5:0]  fifo_count;

  int checks = 0;
  int failures = 0;

  logic [55:0] sb_q[$];
  logic [47:0] rec_q[$];
  logic [23:0] tb_ts;

  event_readout #(.DEPTH(16), .TS_W(24)) dut (
    .pll_clk      (pll_clk),
    .reset        (rst_n),
    .commit_valid (commit_valid),
    .commit_data  (commit_data),
    .spi_clk      (spi_clk),
    .spi_cs       (spi_cs),
    .spi_so       (spi_so),
    .irq_n        (irq_n),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  always #12.5 pll_clk = ~pll_clk;

  always @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 24'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: collect bits on SCK rises; a complete 56-bit frame is compared with the queue head.
  initial begin
    logic [55:0] bits;
    logic [55:0] exp;
    int n;
    forever begin
      @(negedge spi_cs);
      n = 0;
      bits = '0;
      forever begin
        @(posedge spi_clk or posedge spi_cs);
        if (spi_cs) break;
        bits = {bits[54:0], spi_so};
        n++;
      end
      if (n == 56) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame: got %0h expected no frame", bits);
        end else begin
          exp = sb_q.pop_front();
          check("frame", bits, exp);
        end
      end
    end
  end

  task automatic push(input logic [23:0] d);
    logic [23:0] cap;
    @(posedge pll_clk);
    #1;
    commit_valid = 1'b1;
    commit_data  = d;
    cap          = tb_ts;
    @(posedge pll_clk);
    #1;
    commit_valid = 1'b0;
    if (rec_q.size() < 16) rec_q.push_back({cap, d});
  endtask

  task automatic frame(input int nbits, input logic [55:0] exp,
                       input logic push_at_pop, input logic [23:0] pd);
    logic [23:0] cap;
    cap = '0;
    if (nbits == 56) sb_q.push_back(exp);
    @(posedge pll_clk);
    #5;
    spi_cs = 1'b0;
    #250;
    for (int i = 0; i < nbits; i++) begin
      spi_clk = 1'b1;
      #125;
      spi_clk = 1'b0;
      #125;
    end
    @(posedge pll_clk);
    #1;
    spi_cs = 1'b1;
    if (push_at_pop) begin
      // Pop lands on the third edge after CS rises; present a commit on exactly that edge.
      @(posedge pll_clk);
      @(posedge pll_clk);
      #1;
      commit_valid = 1'b1;
      commit_data  = pd;
      cap          = tb_ts;
      @(posedge pll_clk);
      #1;
      commit_valid = 1'b0;
    end
    repeat (8) @(posedge pll_clk);
    #1;
    if (nbits == 56 && rec_q.size() > 0) void'(rec_q.pop_front());
    if (push_at_pop) rec_q.push_back({cap, pd});
  endtask

  initial begin
    #40;
    check("rst_spi_so", 64'(spi_so), 64'd0);
    check("rst_irq_n", 64'(irq_n), 64'd1);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);

    @(negedge pll_clk);
    rst_n = 1'b1;
    repeat (15) @(posedge pll_clk);
    push(24'hA5A5A5);
    check("single_count", 64'(fifo_count), 64'd1);
    check("single_irq", 64'(irq_n), 64'd0);
    frame(56, 56'h01_000010_A5A5A5, 1'b0, '0);
    check("single_count_after", 64'(fifo_count), 64'd0);
    check("single_irq_after", 64'(irq_n), 64'd1);

    frame(56, 56'h80_000000_000000, 1'b0, '0);
    check("empty_count", 64'(fifo_count), 64'd0);

    for (int i = 0; i < 17; i++) push(24'h100 + 24'(i));
    check("ovf_count", 64'(fifo_count), 64'd16);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_irq", 64'(irq_n), 64'd0);
    frame(56, {8'h50, rec_q[0]}, 1'b0, '0);
    check("ovf_flag_after", 64'(overflow), 64'd0);
    check("ovf_count_after", 64'(fifo_count), 64'd15);

    frame(30, '0, 1'b0, '0);
    check("abort_count", 64'(fifo_count), 64'd15);
    frame(56, {8'h0F, rec_q[0]}, 1'b0, '0);
    check("after_abort_count", 64'(fifo_count), 64'd14);

    fork
      frame(56, {8'h0E, rec_q[0]}, 1'b0, '0);
      begin
        #4000;
        push(24'hC0FFEE);
        check("midframe_count", 64'(fifo_count), 64'd15);
      end
    join
    check("midframe_count_after", 64'(fifo_count), 64'd14);

    push(24'h222222);
    push(24'h333333);
    check("full_count", 64'(fifo_count), 64'd16);
    frame(56, {8'h10, rec_q[0]}, 1'b1, 24'h444444);
    check("pushpop_count", 64'(fifo_count), 64'd16);
    check("pushpop_overflow", 64'(overflow), 64'd0);

    // Drain: exposes every stored record in order, so a stored 17th record would surface here.
    for (int i = 16; i > 0; i--) begin
      frame(56, {2'b00, 6'(i), rec_q[0]}, 1'b0, '0);
    end
    check("drain_count", 64'(fifo_count), 64'd0);
    check("drain_irq", 64'(irq_n), 64'd1);

    push(24'h555555);
    push(24'h666666);
    @(posedge pll_clk);
    #5;
    spi_cs = 1'b0;
    #250;
    for (int i = 0; i < 10; i++) begin
      spi_clk = 1'b1;
      #125;
      spi_clk = 1'b0;
      #125;
    end
    #60;
    rst_n = 1'b0;
    #1;
    check("mid_rst_spi_so", 64'(spi_so), 64'd0);
    check("mid_rst_irq_n", 64'(irq_n), 64'd1);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    check("mid_rst_count", 64'(fifo_count), 64'd0);
    rec_q.delete();
    #100;
    @(negedge pll_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #125;
      check("post_rst_so", 64'(spi_so), 64'd0);
      spi_clk = 1'b1;
      #125;
      spi_clk = 1'b0;
    end
    spi_cs = 1'b1;
    repeat (8) @(posedge pll_clk);
    #1;
    check("post_rst_count", 64'(fifo_count), 64'd0);
    check("post_rst_irq", 64'(irq_n), 64'd1);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
